// File: rtl/decode_pkg.sv
// decode_pkg: opcodes, field positions and immediate modes shared by the decode stage
package decode_pkg;
  localparam logic [4:0] OP_LW = 5'b00000;
  localparam logic [4:0] OP_SW = 5'b00001;
  localparam logic [4:0] OP_MOV = 5'b00010;
  localparam logic [4:0] OP_ADD = 5'b00011;
  localparam logic [4:0] OP_NOT = 5'b01100;
  localparam logic [4:0] OP_JR = 5'b01101;
  localparam logic [4:0] OP_JPC = 5'b01110;
  localparam logic [4:0] OP_BRFL = 5'b01111;
  localparam logic [4:0] OP_CALL = 5'b10000;
  localparam logic [4:0] OP_RET = 5'b10001;
  localparam logic [4:0] OP_NOP = 5'b10010;
  localparam logic [4:0] OP_LAST_LEGAL = 5'b10010;
  localparam int OP_HI = 31, OP_LO = 27;
  localparam int LW_RD_HI = 26, LW_RD_LO = 22;
  localparam int RB_HI = 4, RB_LO = 0;
  localparam int MEM_IMM_HI = 21, MEM_IMM_LO = 6;
  localparam int ALU_RD_HI = 21, ALU_RD_LO = 17;
  localparam int ALU_RS_HI = 16, ALU_RS_LO = 12;
  localparam int R_HI = 14, R_LO = 10;
  localparam int BR_IMM_HI = 9, BR_IMM_LO = 5;
  localparam int JPC_IMM_HI = 13, JPC_IMM_LO = 7;
  localparam int IMM_UPPER = 0, IMM_SEXT = 1, IMM_ZEXT = 2;
  typedef struct packed {
    logic [4:0] opcode, rd, rs, rb, r, m;
    logic illegal;
  } dec_fields_t;
  localparam int FIELDS_W = $bits(dec_fields_t);
endpackage

// File: rtl/decode_stage_if.sv
// decode_stage_if: fetch-side and execute-side handshakes of the decode stage
interface decode_stage_if #(parameter int DATA_WIDTH = 32, parameter int PC_WIDTH = 32);
  logic in_valid, in_ready, out_valid, out_ready, out_illegal;
  logic [31:0] in_instr;
  logic [PC_WIDTH-1:0] in_pc, out_pc;
  logic [4:0] out_opcode, out_rd, out_rs, out_rb, out_r, out_m;
  logic [DATA_WIDTH-1:0] out_imm;
  modport master (output in_valid, in_instr, in_pc, out_ready,
                  input in_ready, out_valid, out_opcode, out_rd, out_rs, out_rb, out_r, out_m,
                  out_imm, out_illegal, out_pc);
  modport slave (input in_valid, in_instr, in_pc, out_ready,
                 output in_ready, out_valid, out_opcode, out_rd, out_rs, out_rb, out_r, out_m,
                 out_imm, out_illegal, out_pc);
endinterface

// File: rtl/decode_fields.sv
// decode_fields: combinational instruction word to register fields, immediate and illegal flag
module decode_fields import decode_pkg::*; #(
  parameter int DATA_WIDTH = 32,
  parameter int IMM_MODE = 0,
  parameter int BRFL_SIGNED = 0
) (
  input  logic [31:0] instr,
  output dec_fields_t f,
  output logic [DATA_WIDTH-1:0] imm
);
  logic [4:0] op, i5;
  logic [15:0] i16;
  logic [6:0] i7;
  logic [DATA_WIDTH-1:0] imm16, imm7, imm5;
  assign op = instr[OP_HI:OP_LO];
  assign i16 = instr[MEM_IMM_HI:MEM_IMM_LO];
  assign i7 = instr[JPC_IMM_HI:JPC_IMM_LO];
  assign i5 = instr[BR_IMM_HI:BR_IMM_LO];
  assign imm16 = IMM_MODE == IMM_UPPER ? DATA_WIDTH'({i16, 16'h0}) :
                 IMM_MODE == IMM_SEXT ? {{(DATA_WIDTH-16){i16[15]}}, i16} : DATA_WIDTH'(i16);
  assign imm7 = IMM_MODE == IMM_UPPER ? DATA_WIDTH'({i7, 16'h0}) :
                IMM_MODE == IMM_SEXT ? {{(DATA_WIDTH-7){i7[6]}}, i7} : DATA_WIDTH'(i7);
  assign imm5 = BRFL_SIGNED != 0 ? {{(DATA_WIDTH-5){i5[4]}}, i5} : DATA_WIDTH'(i5);
  // unused fields stay zero so nothing leaks from earlier instructions
  always_comb begin
    f = '0;
    imm = '0;
    f.opcode = op;
    f.illegal = op > OP_LAST_LEGAL;
    if (op == OP_LW || op == OP_MOV) f.rd = instr[LW_RD_HI:LW_RD_LO];
    if (op == OP_SW) f.rs = instr[LW_RD_HI:LW_RD_LO];
    if (op == OP_MOV) f.rs = instr[RB_HI:RB_LO];
    if (op == OP_LW || op == OP_SW) begin
      f.rb = instr[RB_HI:RB_LO];
      imm = imm16;
    end
    if (op >= OP_ADD && op <= OP_NOT) begin
      f.rd = instr[ALU_RD_HI:ALU_RD_LO];
      f.rs = instr[ALU_RS_HI:ALU_RS_LO];
    end
    if (op == OP_JR || op == OP_CALL || op == OP_BRFL) f.r = instr[R_HI:R_LO];
    if (op == OP_BRFL) begin
      f.m = instr[RB_HI:RB_LO];
      imm = imm5;
    end
    if (op == OP_JPC) imm = imm7;
  end
endmodule

// File: rtl/decode_stage.sv
// decode_stage: handshaked decode with a 2-entry skid buffer and branch flush
module decode_stage import decode_pkg::*; #(
  parameter int DATA_WIDTH = 32,
  parameter int PC_WIDTH = 32,
  parameter int IMM_MODE = 0,
  parameter int BRFL_SIGNED = 0
) (
  input logic clock,
  input logic reset,
  input logic flush,
  decode_stage_if.slave bus
);
  localparam int EW = FIELDS_W + DATA_WIDTH + PC_WIDTH;
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  state_t state, state_nx;
  dec_fields_t f;
  logic [DATA_WIDTH-1:0] imm;
  logic [EW-1:0] dec, head, skid;
  logic push, pop, ld_in, ld_skid, ld_tail;
  decode_fields #(.DATA_WIDTH(DATA_WIDTH), .IMM_MODE(IMM_MODE), .BRFL_SIGNED(BRFL_SIGNED))
    u_fields (.instr(bus.in_instr), .f(f), .imm(imm));
  assign dec = {f, imm, bus.in_pc};
  assign push = bus.in_valid && bus.in_ready;
  assign pop = bus.out_valid && bus.out_ready;
  assign bus.in_ready = state != FULL;
  assign bus.out_valid = state != EMPTY;
  assign {bus.out_opcode, bus.out_rd, bus.out_rs, bus.out_rb, bus.out_r, bus.out_m,
          bus.out_illegal, bus.out_imm, bus.out_pc} = head;
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= EMPTY;
    else state <= state_nx;
  // flush leaves every load disabled, so buffered data simply goes stale behind out_valid=0
  always_comb begin
    state_nx = state;
    ld_in = 1'b0;
    ld_skid = 1'b0;
    ld_tail = 1'b0;
    if (flush) state_nx = EMPTY;
    else case (state)
      EMPTY: begin
        ld_in = push;
        state_nx = push ? ONE : EMPTY;
      end
      ONE: begin
        ld_in = push && pop;
        ld_skid = push && !pop;
        state_nx = push == pop ? ONE : push ? FULL : EMPTY;
      end
      default: begin
        ld_tail = pop;
        state_nx = pop ? ONE : FULL;
      end
    endcase
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      head <= '0;
      skid <= '0;
    end else begin
      if (ld_in) head <= dec;
      else if (ld_tail) head <= skid;
      if (ld_skid) skid <= dec;
    end
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed and randomized checks of decode_stage against a FIFO/decoder model
module tb_decode_stage;
  typedef struct packed {
    logic [4:0] opcode, rd, rs, rb, r, m;
    logic illegal;
    logic [31:0] imm;
  } exp_t;
  typedef struct {logic [31:0] instr; logic [31:0] pc;} txn_t;

  logic clock = 1'b0, reset = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] in_instr = '0, in_pc = '0;
  int checks = 0, errors = 0;
  txn_t q[$];
  exp_t e0, e1, e2;
  bit mrdy;

  always #5 clock = ~clock;

  decode_stage_if #(.DATA_WIDTH(32), .PC_WIDTH(32)) b0 ();
  decode_stage_if #(.DATA_WIDTH(32), .PC_WIDTH(32)) b1 ();
  decode_stage_if #(.DATA_WIDTH(32), .PC_WIDTH(32)) b2 ();
  assign b0.in_valid = in_valid;
  assign b0.in_instr = in_instr;
  assign b0.in_pc = in_pc;
  assign b0.out_ready = out_ready;
  assign b1.in_valid = in_valid;
  assign b1.in_instr = in_instr;
  assign b1.in_pc = in_pc;
  assign b1.out_ready = out_ready;
  assign b2.in_valid = in_valid;
  assign b2.in_instr = in_instr;
  assign b2.in_pc = in_pc;
  assign b2.out_ready = out_ready;

  decode_stage #(.IMM_MODE(0), .BRFL_SIGNED(0)) u0 (.clock(clock), .reset(reset), .flush(flush), .bus(b0));
  decode_stage #(.IMM_MODE(1), .BRFL_SIGNED(1)) u1 (.clock(clock), .reset(reset), .flush(flush), .bus(b1));
  decode_stage #(.IMM_MODE(2), .BRFL_SIGNED(0)) u2 (.clock(clock), .reset(reset), .flush(flush), .bus(b2));

  function automatic logic [31:0] ext(input int v, input int bits, input int mode);
    if (mode == 0) return 32'(v) << 16;
    if (mode == 1 && v >= (1 << (bits - 1))) return 32'(v - (1 << bits));
    return 32'(v);
  endfunction

  function automatic exp_t model(input logic [31:0] w, input int mode, input bit bs);
    exp_t e;
    int op;
    e = '0;
    op = int'(w[31:27]);
    e.opcode = w[31:27];
    if (op > 18) e.illegal = 1'b1;
    else if (op == 0) begin e.rd = w[26:22]; e.rb = w[4:0]; e.imm = ext(int'(w[21:6]), 16, mode); end
    else if (op == 1) begin e.rs = w[26:22]; e.rb = w[4:0]; e.imm = ext(int'(w[21:6]), 16, mode); end
    else if (op == 2) begin e.rd = w[26:22]; e.rs = w[4:0]; end
    else if (op <= 12) begin e.rd = w[21:17]; e.rs = w[16:12]; end
    else if (op == 13 || op == 16) e.r = w[14:10];
    else if (op == 14) e.imm = ext(int'(w[13:7]), 7, mode);
    else if (op == 15) begin e.r = w[14:10]; e.m = w[4:0]; e.imm = ext(int'(w[9:5]), 5, bs ? 1 : 2); end
    return e;
  endfunction

  // scoreboard: capacity-2 FIFO of accepted instructions, decoded only when they reach the head
  always @(negedge clock) begin
    if (reset) q.delete();
    else begin
      checks++;
      if (b0.out_valid !== (q.size() != 0) || b0.in_ready !== (q.size() < 2)) begin
        errors++;
        $display("FAIL handshake out_valid=%b in_ready=%b model_depth=%0d", b0.out_valid, b0.in_ready, q.size());
      end
      if (q.size() != 0) begin
        e0 = model(q[0].instr, 0, 1'b0);
        e1 = model(q[0].instr, 1, 1'b1);
        e2 = model(q[0].instr, 2, 1'b0);
        checks++;
        if ({b0.out_opcode, b0.out_rd, b0.out_rs, b0.out_rb, b0.out_r, b0.out_m, b0.out_illegal, b0.out_imm, b0.out_pc}
            !== {e0, q[0].pc}) begin
          errors++;
          $display("FAIL head instr=%h got op=%h rd=%0d rs=%0d rb=%0d r=%0d m=%0d ill=%b imm=%h pc=%h want %h pc=%h",
                   q[0].instr, b0.out_opcode, b0.out_rd, b0.out_rs, b0.out_rb, b0.out_r, b0.out_m,
                   b0.out_illegal, b0.out_imm, b0.out_pc, e0, q[0].pc);
        end
        checks++;
        if (b1.out_imm !== e1.imm || b2.out_imm !== e2.imm) begin
          errors++;
          $display("FAIL imm_modes instr=%h got sext=%h zext=%h want %h %h", q[0].instr, b1.out_imm, b2.out_imm, e1.imm, e2.imm);
        end
      end
      mrdy = q.size() < 2;
      if (flush) q.delete();
      else begin
        if (q.size() != 0 && out_ready) void'(q.pop_front());
        if (in_valid && mrdy) q.push_back('{in_instr, in_pc});
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc, input logic rdy, input logic fl);
    in_valid = v;
    in_instr = ins;
    in_pc = pc;
    out_ready = rdy;
    flush = fl;
  endtask

  task automatic test_reset();
    @(negedge clock);
    checks++;
    if ({b0.out_valid, b0.in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL reset_hs valid=%b ready=%b want 0 1", b0.out_valid, b0.in_ready);
    end
    checks++;
    if ({b0.out_opcode, b0.out_rd, b0.out_rs, b0.out_rb, b0.out_r, b0.out_m, b0.out_illegal, b0.out_imm, b0.out_pc} !== '0) begin
      errors++;
      $display("FAIL reset_fields imm=%h pc=%h rd=%0d want all zero", b0.out_imm, b0.out_pc, b0.out_rd);
    end
  endtask

  task automatic test_lw();
    tick(); drive(1, 32'h00C48D07, 32'h100, 1, 0);
    tick(); drive(0, 0, 0, 1, 0);
    @(negedge clock);
    checks++;
    if ({b0.out_valid, b0.out_rd, b0.out_rb, b0.out_rs, b0.out_imm, b0.out_pc} !== {1'b1, 5'd3, 5'd7, 5'd0, 32'h12340000, 32'h100}) begin
      errors++;
      $display("FAIL lw valid=%b rd=%0d rb=%0d rs=%0d imm=%h pc=%h want 1 3 7 0 12340000 100",
               b0.out_valid, b0.out_rd, b0.out_rb, b0.out_rs, b0.out_imm, b0.out_pc);
    end
  endtask

  task automatic test_sw();
    tick(); drive(1, 32'h09600042, 32'h104, 1, 0);
    tick(); drive(0, 0, 0, 1, 0);
    @(negedge clock);
    checks++;
    if ({b0.out_rs, b0.out_rb, b0.out_rd} !== {5'd5, 5'd2, 5'd0}) begin
      errors++;
      $display("FAIL sw_fields rs=%0d rb=%0d rd=%0d want 5 2 0", b0.out_rs, b0.out_rb, b0.out_rd);
    end
    checks++;
    if ({b0.out_imm, b1.out_imm, b2.out_imm} !== {32'h80010000, 32'hFFFF8001, 32'h00008001}) begin
      errors++;
      $display("FAIL sw_imm upper=%h sext=%h zext=%h want 80010000 ffff8001 00008001", b0.out_imm, b1.out_imm, b2.out_imm);
    end
  endtask

  task automatic test_back_to_back();
    tick(); drive(1, 32'h18049000, 32'h200, 1, 0);
    tick(); drive(1, 32'hA7FFFFFF, 32'h204, 1, 0);
    @(negedge clock);
    checks++;
    if ({b0.out_valid, b0.out_rd, b0.out_rs, b0.out_illegal} !== {1'b1, 5'd2, 5'd9, 1'b0}) begin
      errors++;
      $display("FAIL add valid=%b rd=%0d rs=%0d ill=%b want 1 2 9 0", b0.out_valid, b0.out_rd, b0.out_rs, b0.out_illegal);
    end
    tick(); drive(0, 0, 0, 1, 0);
    @(negedge clock);
    checks++;
    if ({b0.out_valid, b0.out_opcode, b0.out_illegal, b0.out_rd, b0.out_rs, b0.out_rb, b0.out_r, b0.out_m, b0.out_imm, b0.out_pc}
        !== {1'b1, 5'b10100, 1'b1, 25'd0, 32'd0, 32'h204}) begin
      errors++;
      $display("FAIL illegal valid=%b op=%b ill=%b rd=%0d rs=%0d r=%0d m=%0d imm=%h pc=%h want 1 10100 1 zeros pc 204",
               b0.out_valid, b0.out_opcode, b0.out_illegal, b0.out_rd, b0.out_rs, b0.out_r, b0.out_m, b0.out_imm, b0.out_pc);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] ins[3];
    int v[7] = '{1, 1, 1, 1, 1, 0, 0};
    int rdy[7] = '{0, 0, 0, 1, 1, 1, 1};
    int sel[7] = '{0, 1, 2, 2, 2, 0, 0};
    int xr[7] = '{1, 1, 0, 0, 1, 1, 1};
    int xv[7] = '{0, 1, 1, 1, 1, 1, 0};
    logic [31:0] xpc[7] = '{32'h0, 32'hA0, 32'hA0, 32'hA0, 32'hB0, 32'hC0, 32'h0};
    logic [31:0] pcs[3] = '{32'hA0, 32'hB0, 32'hC0};
    foreach (ins[i]) ins[i] = $urandom;
    for (int k = 0; k < 7; k++) begin
      tick(); drive(v[k] != 0, ins[sel[k]], pcs[sel[k]], rdy[k] != 0, 0);
      @(negedge clock);
      checks++;
      if (b0.in_ready !== (xr[k] != 0) || b0.out_valid !== (xv[k] != 0) || (xv[k] != 0 && b0.out_pc !== xpc[k])) begin
        errors++;
        $display("FAIL backpressure step %0d ready=%b valid=%b pc=%h want %0d %0d %h", k, b0.in_ready, b0.out_valid, b0.out_pc, xr[k], xv[k], xpc[k]);
      end
    end
  endtask

  task automatic test_flush();
    tick(); drive(1, $urandom, 32'hE0, 0, 0);
    tick(); drive(1, $urandom, 32'hE1, 0, 0);
    tick(); drive(1, $urandom, 32'hDD, 0, 1);
    @(negedge clock);
    checks++;
    if ({b0.in_ready, b0.out_valid} !== 2'b01) begin
      errors++;
      $display("FAIL flush_full_pre ready=%b valid=%b want 0 1", b0.in_ready, b0.out_valid);
    end
    tick(); drive(0, 0, 0, 1, 0);
    @(negedge clock);
    checks++;
    if ({b0.in_ready, b0.out_valid} !== 2'b10) begin
      errors++;
      $display("FAIL flush_full ready=%b valid=%b want 1 0", b0.in_ready, b0.out_valid);
    end
    tick(); drive(1, $urandom, 32'hF0, 0, 0);
    tick(); drive(1, $urandom, 32'hDE, 0, 1);
    tick(); drive(0, 0, 0, 1, 0);
    @(negedge clock);
    checks++;
    if ({b0.in_ready, b0.out_valid} !== 2'b10) begin
      errors++;
      $display("FAIL flush_one ready=%b valid=%b want 1 0", b0.in_ready, b0.out_valid);
    end
    tick();
    @(negedge clock);
    checks++;
    if (b0.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_drop valid=%b pc=%h want 0", b0.out_valid, b0.out_pc);
    end
  endtask

  task automatic test_async_reset();
    tick(); drive(1, $urandom, 32'h30, 0, 0);
    tick(); drive(1, $urandom, 32'h34, 0, 0);
    tick(); drive(0, 0, 0, 0, 0);
    @(negedge clock);
    checks++;
    if (b0.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL areset_pre ready=%b want 0", b0.in_ready);
    end
    @(posedge clock);
    #3 reset = 1'b1;
    #1;
    checks++;
    if ({b0.out_valid, b0.in_ready, b0.out_opcode, b0.out_rd, b0.out_rs, b0.out_rb, b0.out_r, b0.out_m,
         b0.out_illegal, b0.out_imm, b0.out_pc} !== {1'b0, 1'b1, 95'd0}) begin
      errors++;
      $display("FAIL areset valid=%b ready=%b imm=%h pc=%h op=%b want 0 1 zeros", b0.out_valid, b0.in_ready, b0.out_imm, b0.out_pc, b0.out_opcode);
    end
    @(negedge clock);
    #2 reset = 1'b0;
    tick(); drive(1, 32'h00C48D07, 32'h44, 1, 0);
    tick(); drive(0, 0, 0, 1, 0);
    @(negedge clock);
    checks++;
    if ({b0.out_valid, b0.out_rd, b0.out_rb, b0.out_imm, b0.out_pc} !== {1'b1, 5'd3, 5'd7, 32'h12340000, 32'h44}) begin
      errors++;
      $display("FAIL areset_after valid=%b rd=%0d rb=%0d imm=%h pc=%h want 1 3 7 12340000 44",
               b0.out_valid, b0.out_rd, b0.out_rb, b0.out_imm, b0.out_pc);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 500; n++) begin
      tick();
      drive($urandom_range(0, 3) != 0, {5'($urandom_range(0, 22)), 27'($urandom)}, $urandom,
            $urandom_range(0, 2) != 0, $urandom_range(0, 24) == 0);
    end
    for (int n = 0; n < 4; n++) begin
      tick(); drive(0, 0, 0, 1, 0);
    end
  endtask

  initial begin
    repeat (2) @(posedge clock);
    @(negedge clock);
    #2 reset = 1'b0;
    test_reset();
    test_lw();
    test_sw();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_random();
    @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
Parametrised, handshaked instruction-decode stage between fetch and execute.
Decodes the instruction presented in the same transfer, with no one-cycle opcode lag, into register indices, an extended immediate and an illegal flag.
Carries a 2-entry skid buffer so that back-pressure from execute never drops or duplicates an instruction.
Supports a pipeline flush from branch resolution.

Parameters:
DATA_WIDTH, 32, width of out_imm; must be >= 32.
PC_WIDTH, 32, width of the pc side-band carried with each instruction.
IMM_MODE, 0, LW/SW/JPC immediate form: 0 = field placed at bit 16 and up (lower 16 bits zero), 1 = sign-extend, 2 = zero-extend.
BRFL_SIGNED, 0, 1 = sign-extend the BRFL 5-bit immediate; 0 = zero-extend it.

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
flush  in  1  synchronous: discard all buffered and incoming instructions
in_valid  in  1  fetch presents an instruction
in_ready  out  1  stage can accept an instruction
in_instr  in  32  instruction word
in_pc  in  PC_WIDTH  address of in_instr
out_valid  out  1  decoded instruction available
out_ready  in  1  execute accepts the instruction
out_opcode  out  5  in_instr[31:27]
out_rd, out_rs, out_rb, out_r, out_m  out  5 each  register and mask fields
out_imm  out  DATA_WIDTH  extended immediate
out_illegal  out  1  opcode is not in the defined set
out_pc  out  PC_WIDTH  pc of the decoded instruction

Behaviour:
- Transfers: input accepted when in_valid && in_ready; output consumed when out_valid && out_ready.
- Decode is combinational on in_instr and is captured into the buffer, giving a fixed 1-cycle latency.
- Field extraction. Any field not used by a format is 0, never held from an earlier instruction.
  - LW (00000): rd=[26:22], rb=[4:0], imm from [21:6].
  - SW (00001): rs=[26:22], rb=[4:0], imm from [21:6].
  - MOV (00010): rd=[26:22], rs=[4:0].
  - ADD..NOT (00011-01100): rd=[21:17], rs=[16:12].
  - JR (01101) and CALL (10000): r=[14:10].
  - BRFL (01111): r=[14:10], m=[4:0], imm from [9:5] per BRFL_SIGNED.
  - JPC (01110): imm from [13:7], 7-bit, extended per IMM_MODE; in mode 0 placed at bit 16.
  - RET (10001) and NOP (10010): all fields 0.
  - Opcodes 10011-11111: out_illegal=1, all fields and imm 0. The instruction still flows through so execute can trap.
- Skid buffer states, by count: EMPTY(0), ONE(1), FULL(2).
  - in_ready = (state != FULL), driven from a register with no combinational path from out_ready.
  - out_valid = (state != EMPTY). Head entry drives the out_* ports.
  - EMPTY: push -> ONE.
  - ONE: push only -> FULL; pop only -> EMPTY; push and pop together -> ONE, head replaced by the new entry.
  - FULL: pop -> ONE, second entry moves to the head. No push is possible in FULL.
  - Ordering is strictly FIFO. Throughput is 1 instruction/cycle while out_ready is held high.
- Flush: on a clock edge with flush=1, state -> EMPTY and both entries are invalidated. An input presented that same cycle is dropped. Next cycle: out_valid=0, in_ready=1. Flush has priority over push and pop.
- Reset (asynchronous, any time, including mid-transfer): state=EMPTY, in_ready=1, out_valid=0, every out_* field and out_pc = 0, out_illegal=0.
- Stability: out_* fields hold while out_valid && !out_ready.

Decomposition:
- decode_pkg:
  - opcode localparams (OP_LW .. OP_NOP) and OP_LAST_LEGAL = 5'b10010;
  - field bit positions (LW_RD_HI/LO etc.);
  - IMM_MODE encodings (IMM_UPPER=0, IMM_SEXT=1, IMM_ZEXT=2);
  - decoded-entry struct width constant.
- One sub-module, decode_fields: purely combinational map from instr to {opcode, rd, rs, rb, r, m, imm, illegal}, parametrised by DATA_WIDTH, IMM_MODE, BRFL_SIGNED.
- decode_stage itself holds the skid buffer, handshake and flush logic.

Test Plan:
- LW 32'h00C48D07 (rd=3, field 0x1234, rb=7), IMM_MODE=0, out_ready=1 -> next cycle out_valid=1, rd=3, rb=7, rs=0, imm=32'h1234_0000.
- SW with field 0x8001, IMM_MODE=1 -> imm=32'hFFFF_8001. Same word with IMM_MODE=2 -> imm=32'h0000_8001.
- ADD 32'h1804_9000 then opcode 5'b10100 back-to-back -> ADD gives rd=2, rs=9, illegal=0; next gives illegal=1, all fields 0.
- Hold out_ready=0, push 3 instructions A, B, C -> in_ready drops after A and B are accepted, C is held by fetch. Release out_ready -> A, B, C emerge in order, no duplicates, 1 per cycle.
- FULL state, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1; the flushed-cycle input never appears at the output.
- Assert reset asynchronously, between clock edges, while FULL -> all outputs 0 and in_ready=1 immediately. After release, the first new instruction decodes correctly.
